// File: rtl/core_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes, FSM states and mux selects.
package core_pkg;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  typedef enum logic [1:0] {
    PcPlus4  = 2'd0,
    PcBranch = 2'd1,
    PcJalr   = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    WbAlu  = 2'd0,
    WbLoad = 2'd1,
    WbPc4  = 2'd2,
    WbImm  = 2'd3
  } wb_sel_e;

  function automatic logic opcode_valid(logic [6:0] opc);
    return (opc == OpcOp)    || (opc == OpcOpImm)  || (opc == OpcLoad) ||
           (opc == OpcStore) || (opc == OpcBranch) || (opc == OpcLui)  ||
           (opc == OpcAuipc) || (opc == OpcJal)    || (opc == OpcJalr);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_perf_counters.sv
// Free-running cycle counter and retired-instruction counter; both wrap silently.
module perf_counters #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             retire_i,
  output logic [Width-1:0] cycle_cnt_o,
  output logic [Width-1:0] instret_cnt_o
);

  logic [Width-1:0] cycle_q, cycle_d;
  logic [Width-1:0] instret_q, instret_d;

  always_comb begin
    cycle_d   = cycle_q + Width'(1);
    instret_d = retire_i ? instret_q + Width'(1) : instret_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt_o   = cycle_q;
  assign instret_cnt_o = instret_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a sticky TRAP state.
module multicycle_ctrl
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic            branch_taken_i,
  input  logic            imem_ready_i,
  input  logic            dmem_ready_i,
  output logic            imem_req_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [2:0]      mem_size_o,
  output logic            ir_we_o,
  output logic            pc_we_o,
  output logic [1:0]      pc_sel_o,
  output logic            rf_we_o,
  output logic [1:0]      wb_sel_o,
  output logic            alu_a_pc_o,
  output logic            alu_b_imm_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] cycle_cnt_o,
  output logic [XLEN-1:0] instret_cnt_o
);

  state_e state_q, state_d;
  logic   retire;

  logic is_op, is_load, is_store, is_branch, is_lui, is_auipc, is_jal, is_jalr;
  assign is_op     = (opcode_i == OpcOp);
  assign is_load   = (opcode_i == OpcLoad);
  assign is_store  = (opcode_i == OpcStore);
  assign is_branch = (opcode_i == OpcBranch);
  assign is_lui    = (opcode_i == OpcLui);
  assign is_auipc  = (opcode_i == OpcAuipc);
  assign is_jal    = (opcode_i == OpcJal);
  assign is_jalr   = (opcode_i == OpcJalr);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (imem_ready_i) state_d = StDecode;
      StDecode: state_d = opcode_valid(opcode_i) ? StExec : StTrap;
      StExec: begin
        if (is_load || is_store) state_d = StMem;
        else if (is_branch)      state_d = StFetch;
        else                     state_d = StWb;
      end
      StMem:    if (dmem_ready_i) state_d = is_store ? StFetch : StWb;
      StWb:     state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StFetch;
    endcase
  end

  // Everything is forced low while reset is held, including the FETCH request.
  always_comb begin
    imem_req_o  = 1'b0;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    mem_size_o  = 3'd0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_sel_o    = PcPlus4;
    rf_we_o     = 1'b0;
    wb_sel_o    = WbAlu;
    alu_a_pc_o  = 1'b0;
    alu_b_imm_o = 1'b0;
    illegal_o   = 1'b0;
    retire      = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        StFetch: begin
          imem_req_o = 1'b1;
          ir_we_o    = imem_ready_i;
        end
        StExec: begin
          alu_b_imm_o = !(is_op || is_branch);
          alu_a_pc_o  = is_auipc;
          if (is_branch) begin
            pc_we_o  = 1'b1;
            pc_sel_o = branch_taken_i ? PcBranch : PcPlus4;
            retire   = 1'b1;
          end
        end
        StMem: begin
          dmem_req_o = 1'b1;
          dmem_we_o  = is_store;
          mem_size_o = funct3_i;
          if (dmem_ready_i && is_store) begin
            pc_we_o = 1'b1;
            retire  = 1'b1;
          end
        end
        StWb: begin
          rf_we_o = 1'b1;
          pc_we_o = 1'b1;
          retire  = 1'b1;
          if (is_load)                wb_sel_o = WbLoad;
          else if (is_jal || is_jalr) wb_sel_o = WbPc4;
          else if (is_lui)            wb_sel_o = WbImm;
          if (is_jal)       pc_sel_o = PcBranch;
          else if (is_jalr) pc_sel_o = PcJalr;
        end
        StTrap:  illegal_o = 1'b1;
        default: ;
      endcase
    end
  end

  perf_counters #(
    .Width(XLEN)
  ) u_perf_counters (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .retire_i      (retire),
    .cycle_cnt_o   (cycle_cnt_o),
    .instret_cnt_o (instret_cnt_o)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected control vectors queued and compared.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic [2:0] mem_size;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       a_pc;
    logic       b_imm;
    logic       illegal;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst, rst_w;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        branch_taken, imem_ready, dmem_ready;
  logic        imem_ready_w;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, alu_a_pc, alu_b_imm, illegal;
  logic [2:0]  mem_size;
  logic [1:0]  pc_sel, wb_sel;
  logic [31:0] cycle_cnt, instret_cnt;
  logic        w_imem_req, w_dmem_req, w_dmem_we, w_ir_we, w_pc_we, w_rf_we;
  logic        w_a_pc, w_b_imm, w_illegal;
  logic [2:0]  w_mem_size;
  logic [1:0]  w_pc_sel, w_wb_sel;
  logic [3:0]  w_cycle_cnt, w_instret_cnt;

  ctl_t  obs;
  ctl_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    failures = 0;
  int    exp_cyc = 0;
  int    exp_ret = 0;

  always #5 clk = ~clk;

  assign obs = {imem_req, dmem_req, dmem_we, mem_size, ir_we, pc_we, pc_sel, rf_we, wb_sel,
                alu_a_pc, alu_b_imm, illegal};

  multicycle_ctrl dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct3_i(funct3),
    .branch_taken_i(branch_taken), .imem_ready_i(imem_ready), .dmem_ready_i(dmem_ready),
    .imem_req_o(imem_req), .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .mem_size_o(mem_size),
    .ir_we_o(ir_we), .pc_we_o(pc_we), .pc_sel_o(pc_sel), .rf_we_o(rf_we), .wb_sel_o(wb_sel),
    .alu_a_pc_o(alu_a_pc), .alu_b_imm_o(alu_b_imm), .illegal_o(illegal),
    .cycle_cnt_o(cycle_cnt), .instret_cnt_o(instret_cnt)
  );

  // Narrow instance parked in FETCH to exercise counter wrap quickly.
  multicycle_ctrl #(.XLEN(4)) dut_w (
    .clk_i(clk), .rst_i(rst_w), .opcode_i(opcode), .funct3_i(funct3),
    .branch_taken_i(branch_taken), .imem_ready_i(imem_ready_w), .dmem_ready_i(dmem_ready),
    .imem_req_o(w_imem_req), .dmem_req_o(w_dmem_req), .dmem_we_o(w_dmem_we),
    .mem_size_o(w_mem_size), .ir_we_o(w_ir_we), .pc_we_o(w_pc_we), .pc_sel_o(w_pc_sel),
    .rf_we_o(w_rf_we), .wb_sel_o(w_wb_sel), .alu_a_pc_o(w_a_pc), .alu_b_imm_o(w_b_imm),
    .illegal_o(w_illegal), .cycle_cnt_o(w_cycle_cnt), .instret_cnt_o(w_instret_cnt)
  );

  function automatic ctl_t e_fetch(input logic rdy);
    ctl_t e = '0;
    e.imem_req = 1'b1;
    e.ir_we    = rdy;
    return e;
  endfunction

  function automatic ctl_t e_exec(input logic bimm, input logic apc, input logic pcwe,
                                  input logic [1:0] pcsel);
    ctl_t e = '0;
    e.b_imm  = bimm;
    e.a_pc   = apc;
    e.pc_we  = pcwe;
    e.pc_sel = pcsel;
    return e;
  endfunction

  function automatic ctl_t e_mem(input logic we, input logic [2:0] sz, input logic st_done);
    ctl_t e = '0;
    e.dmem_req = 1'b1;
    e.dmem_we  = we;
    e.mem_size = sz;
    e.pc_we    = st_done;
    return e;
  endfunction

  function automatic ctl_t e_wb(input logic [1:0] wbsel, input logic [1:0] pcsel);
    ctl_t e = '0;
    e.rf_we  = 1'b1;
    e.pc_we  = 1'b1;
    e.wb_sel = wbsel;
    e.pc_sel = pcsel;
    return e;
  endfunction

  function automatic ctl_t e_trap();
    ctl_t e = '0;
    e.illegal = 1'b1;
    return e;
  endfunction

  task automatic check_ctl();
    ctl_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s ctl got=%h exp=%h", t, obs, e);
    end
  endtask

  task automatic expect_now(input string tag, input ctl_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    check_ctl();
  endtask

  // One clock: drive handshake inputs, queue the expected vector, compare at negedge.
  task automatic cyc(input string tag, input logic ir, input logic dr, input logic bt,
                     input ctl_t e);
    imem_ready   = ir;
    dmem_ready   = dr;
    branch_taken = bt;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check_ctl();
    @(posedge clk);
    #1;
    if (!rst) exp_cyc++;
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic counters(input string tag);
    chk_cnt({tag, " cycle_cnt"}, cycle_cnt, 32'(exp_cyc));
    chk_cnt({tag, " instret_cnt"}, instret_cnt, 32'(exp_ret));
  endtask

  task automatic load_instr(input logic [31:0] w);
    opcode = w[6:0];
    funct3 = w[14:12];
  endtask

  task automatic front(input string tag, input logic [31:0] w, input logic bimm,
                       input logic apc);
    load_instr(w);
    cyc({tag, " fetch"}, 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    cyc({tag, " decode"}, 1'b1, 1'b1, 1'b1, '0);
    cyc({tag, " exec"}, 1'b0, 1'b0, 1'b0, e_exec(bimm, apc, 1'b0, 2'd0));
  endtask

  initial begin
    rst = 1'b1; rst_w = 1'b1;
    opcode = 7'h00; funct3 = 3'd0;
    branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; imem_ready_w = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset held", 1'b1, 1'b1, 1'b1, '0);
    counters("reset");
    rst = 1'b0;

    // ADDI x1,x0,5
    front("addi", 32'h00500093, 1'b1, 1'b0);
    cyc("addi wb", 1'b0, 1'b0, 1'b0, e_wb(2'd0, 2'd0));
    exp_ret++;
    counters("addi");

    // LW with three dmem wait cycles
    front("lw", 32'h0000A103, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("lw mem wait", 1'b0, 1'b0, 1'b0, e_mem(1'b0, 3'd2, 1'b0));
    cyc("lw mem done", 1'b0, 1'b1, 1'b0, e_mem(1'b0, 3'd2, 1'b0));
    cyc("lw wb", 1'b0, 1'b0, 1'b0, e_wb(2'd1, 2'd0));
    exp_ret++;
    counters("lw");

    // BEQ taken, with one fetch wait; stray dmem_ready must be ignored
    load_instr(32'h00000063);
    cyc("beq fetch wait", 1'b0, 1'b1, 1'b0, e_fetch(1'b0));
    cyc("beq fetch", 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    cyc("beq decode", 1'b0, 1'b0, 1'b0, '0);
    cyc("beq exec taken", 1'b0, 1'b0, 1'b1, e_exec(1'b0, 1'b0, 1'b1, 2'd1));
    exp_ret++;
    cyc("beq2 fetch", 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    cyc("beq2 decode", 1'b0, 1'b0, 1'b1, '0);
    cyc("beq2 exec not taken", 1'b0, 1'b0, 1'b0, e_exec(1'b0, 1'b0, 1'b1, 2'd0));
    exp_ret++;
    counters("beq");

    // SW zero-wait
    front("sw", 32'h0020A023, 1'b1, 1'b0);
    cyc("sw mem", 1'b0, 1'b1, 1'b0, e_mem(1'b1, 3'd2, 1'b1));
    exp_ret++;

    front("jalr", 32'h000080E7, 1'b1, 1'b0);
    cyc("jalr wb", 1'b0, 1'b0, 1'b0, e_wb(2'd2, 2'd2));
    exp_ret++;
    front("jal", 32'h0000006F, 1'b1, 1'b0);
    cyc("jal wb", 1'b0, 1'b0, 1'b0, e_wb(2'd2, 2'd1));
    exp_ret++;
    front("lui", 32'h000000B7, 1'b1, 1'b0);
    cyc("lui wb", 1'b0, 1'b0, 1'b0, e_wb(2'd3, 2'd0));
    exp_ret++;
    front("auipc", 32'h00000097, 1'b1, 1'b1);
    cyc("auipc wb", 1'b0, 1'b0, 1'b0, e_wb(2'd0, 2'd0));
    exp_ret++;
    front("add", 32'h00000033, 1'b0, 1'b0);
    cyc("add wb", 1'b0, 1'b0, 1'b0, e_wb(2'd0, 2'd0));
    exp_ret++;
    counters("mixed");

    // Reset during a MEM wait: request abandoned, nothing retires
    front("lw rst", 32'h0000A103, 1'b1, 1'b0);
    cyc("lw rst mem wait", 1'b0, 1'b0, 1'b0, e_mem(1'b0, 3'd2, 1'b0));
    rst = 1'b1;
    #1;
    exp_cyc = 0;
    exp_ret = 0;
    expect_now("rst async outputs", '0);
    counters("rst async");
    cyc("rst held mid-instr", 1'b0, 1'b1, 1'b0, '0);
    rst = 1'b0;
    cyc("post rst fetch", 1'b0, 1'b1, 1'b0, e_fetch(1'b0));
    counters("post rst");

    // Illegal opcode: sticky trap, instret frozen, cycles continue
    load_instr(32'h0000007F);
    cyc("trap fetch", 1'b1, 1'b0, 1'b0, e_fetch(1'b1));
    cyc("trap decode", 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) cyc("trap hold", 1'b1, 1'b1, 1'b1, e_trap());
    counters("trap");
    rst = 1'b1;
    #1;
    exp_cyc = 0;
    expect_now("trap cleared by rst", '0);
    counters("trap rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("after trap fetch", 1'b0, 1'b0, 1'b0, e_fetch(1'b0));

    // 4-bit counter wrap on the narrow instance
    rst_w = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk_cnt("wrap cycle max", 32'(w_cycle_cnt), 32'hF);
    @(posedge clk);
    #1;
    chk_cnt("wrap cycle zero", 32'(w_cycle_cnt), 32'h0);
    chk_cnt("wrap instret", 32'(w_instret_cnt), 32'h0);
    chk_cnt("wrap imem_req held", 32'(w_imem_req), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
